// File: rtl/expr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : expr_pkg
// Purpose  : Shared states, ASCII constants, byte classifier and datapath ops
//            for the expression evaluator.
// Revision : 1.0
// ============================================================================
package expr_pkg;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] NUM   = 2'd1;
    localparam logic [1:0] OP    = 2'd2;
    localparam logic [1:0] ERR   = 2'd3;

    localparam logic [7:0] CH_0    = 8'd48;
    localparam logic [7:0] CH_9    = 8'd57;
    localparam logic [7:0] CH_PLUS = 8'd43;
    localparam logic [7:0] CH_STAR = 8'd42;

    typedef enum logic [1:0] {
        DIGIT = 2'd0,
        PLUS  = 2'd1,
        STAR  = 2'd2,
        OTHER = 2'd3
    } byte_cls_e;

    typedef enum logic [2:0] {
        DP_NOP   = 3'd0,
        DP_FIRST = 3'd1,
        DP_ADD   = 3'd2,
        DP_MUL   = 3'd3,
        DP_TERM  = 3'd4
    } dp_op_e;

    function automatic byte_cls_e classify(input logic [7:0] b);
        if (b >= CH_0 && b <= CH_9) return DIGIT;
        if (b == CH_PLUS)           return PLUS;
        if (b == CH_STAR)           return STAR;
        return OTHER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/expr_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : expr_eval_if
// Purpose  : Byte stream in, result/status out. Optional ovf (EXPR_EVAL_OVF_EN).
// Revision : 1.0
// ============================================================================
interface expr_eval_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic [7:0]   in;
    logic [W-1:0] result;
    logic         ok;
    logic         err;
`ifdef EXPR_EVAL_OVF_EN
    logic         ovf;
`endif

`ifdef EXPR_EVAL_OVF_EN
    modport master (output in_valid, in, input result, ok, err, ovf);
    modport slave  (input in_valid, in, output result, ok, err, ovf);
`else
    modport master (output in_valid, in, input result, ok, err);
    modport slave  (input in_valid, in, output result, ok, err);
`endif

endinterface
`default_nettype wire

// File: rtl/expr_datapath.sv
`default_nettype none
// ============================================================================
// Module   : expr_datapath
// Purpose  : sum/prod/mul registers with the W x 4 multiply and W-bit add.
//            Sticky overflow flag only with EXPR_EVAL_OVF_EN.
// Revision : 1.0
// ============================================================================
module expr_datapath
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         clr_n,
    input  wire logic         sclr_i,
    input  wire dp_op_e       op_i,
    input  wire logic [3:0]   digit_i,
`ifdef EXPR_EVAL_OVF_EN
    output logic              ovf_o,
`endif
    output logic [W-1:0]      result_o
);

    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] prod_q, prod_d;
    logic         mul_q, mul_d;

    logic [W:0]   w_sum_x;
    logic [W+3:0] w_prod_x;
    logic         w_upd_ovf;

    assign w_sum_x  = {1'b0, sum_q} + {1'b0, prod_q};
    assign w_prod_x = {4'b0000, prod_q} * {{W{1'b0}}, digit_i};
    assign result_o = w_sum_x[W-1:0];

    always_comb begin
        sum_d     = sum_q;
        prod_d    = prod_q;
        mul_d     = mul_q;
        w_upd_ovf = 1'b0;
        case (op_i)
            DP_FIRST: begin
                sum_d  = '0;
                prod_d = W'(digit_i);
                mul_d  = 1'b0;
            end
            DP_ADD: begin
                sum_d     = w_sum_x[W-1:0];
                prod_d    = '0;
                mul_d     = 1'b0;
                w_upd_ovf = w_sum_x[W];
            end
            DP_MUL: mul_d = 1'b1;
            DP_TERM: begin
                if (mul_q) begin
                    prod_d    = w_prod_x[W-1:0];
                    w_upd_ovf = |w_prod_x[W+3:W];
                end else begin
                    prod_d = W'(digit_i);
                end
                mul_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sum_q  <= '0;
            prod_q <= '0;
            mul_q  <= 1'b0;
        end else if (sclr_i) begin
            sum_q  <= '0;
            prod_q <= '0;
            mul_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            prod_q <= prod_d;
            mul_q  <= mul_d;
        end
    end

`ifdef EXPR_EVAL_OVF_EN
    logic ovf_q;

    // The live result carry is folded in too, so a term later zeroed by '*0'
    // cannot hide an overflow that was already visible on result.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)      ovf_q <= 1'b0;
        else if (sclr_i) ovf_q <= 1'b0;
        else             ovf_q <= ovf_q | w_upd_ovf | w_sum_x[W];
    end

    assign ovf_o = ovf_q | w_sum_x[W];
`else
    logic w_unused;
    assign w_unused = w_upd_ovf;
`endif

endmodule
`default_nettype wire

// File: rtl/expr_eval.sv
`default_nettype none
// ============================================================================
// Module   : expr_eval
// Purpose  : Evaluates single-digit '+'/'*' expressions with grammar check.
//            Optional sticky overflow output with EXPR_EVAL_OVF_EN.
// Revision : 1.0
// ============================================================================
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  wire logic  clk,
    input  wire logic  clr_n,
    input  wire logic  sclr,
    expr_eval_if.slave bus
);

    logic [1:0] state_q, state_d;
    byte_cls_e  w_cls;
    dp_op_e     w_dp_op;

    assign w_cls = classify(bus.in);

    always_comb begin
        state_d = state_q;
        w_dp_op = DP_NOP;
        if (bus.in_valid) begin
            case (state_q)
                EMPTY: begin
                    if (w_cls == DIGIT) begin
                        state_d = NUM;
                        w_dp_op = DP_FIRST;
                    end else begin
                        state_d = ERR;
                    end
                end
                NUM: begin
                    // A digit right after a digit would be a multi-digit number.
                    case (w_cls)
                        PLUS: begin
                            state_d = OP;
                            w_dp_op = DP_ADD;
                        end
                        STAR: begin
                            state_d = OP;
                            w_dp_op = DP_MUL;
                        end
                        default: state_d = ERR;
                    endcase
                end
                OP: begin
                    if (w_cls == DIGIT) begin
                        state_d = NUM;
                        w_dp_op = DP_TERM;
                    end else begin
                        state_d = ERR;
                    end
                end
                default: state_d = ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)    state_q <= EMPTY;
        else if (sclr) state_q <= EMPTY;
        else           state_q <= state_d;
    end

    expr_datapath #(
        .W (W)
    ) u_datapath (
        .clk      (clk),
        .clr_n    (clr_n),
        .sclr_i   (sclr),
        .op_i     (w_dp_op),
        .digit_i  (bus.in[3:0]),
`ifdef EXPR_EVAL_OVF_EN
        .ovf_o    (bus.ovf),
`endif
        .result_o (bus.result)
    );

    assign bus.ok  = (state_q == NUM);
    assign bus.err = (state_q == ERR);

endmodule
`default_nettype wire

// File: tb/tb_expr_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_expr_eval
// Purpose  : Directed self-checking bench for expr_eval (W=16 and W=8).
// Revision : 1.0
// ============================================================================
module tb_expr_eval;

    logic clk;
    logic clr_n;
    logic sclr;

    int n_tests;
    int n_fail;

    expr_eval_if #(.W(16)) bus16 ();
    expr_eval_if #(.W(8))  bus8  ();

    expr_eval #(.W(16)) dut16 (
        .clk   (clk),
        .clr_n (clr_n),
        .sclr  (sclr),
        .bus   (bus16)
    );

    expr_eval #(.W(8)) dut8 (
        .clk   (clk),
        .clr_n (clr_n),
        .sclr  (sclr),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus16.in_valid = 1'b1;
        bus16.in       = b;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        bus16.in       = 8'h2A;
    endtask

    task automatic send8(input logic [7:0] b);
        bus8.in_valid = 1'b1;
        bus8.in       = b;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.in       = 8'h00;
    endtask

    task automatic stall(input logic [7:0] junk);
        bus16.in_valid = 1'b0;
        bus16.in       = junk;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sclr();
        sclr = 1'b1;
        @(posedge clk);
        #1;
        sclr = 1'b0;
    endtask

    task automatic send_str16(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr_n   = 1'b0;
        sclr    = 1'b0;
        bus16.in_valid = 1'b0;
        bus16.in       = 8'h00;
        bus8.in_valid  = 1'b0;
        bus8.in        = 8'h00;

        #12;
        check("rst_result", 32'(bus16.result), 32'd0);
        check("rst_ok",     32'(bus16.ok),     32'd0);
        check("rst_err",    32'(bus16.err),    32'd0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        // 2+3*4 = 14, with 5 visible while waiting on the last factor
        send_str16("2+3*");
        check("t1_star_ok",     32'(bus16.ok),     32'd0);
        check("t1_star_result", 32'(bus16.result), 32'd5);
        send("4");
        check("t1_ok",     32'(bus16.ok),     32'd1);
        check("t1_result", 32'(bus16.result), 32'd14);
        check("t1_err",    32'(bus16.err),    32'd0);

        // sclr wins over a valid byte on the same edge
        sclr = 1'b1;
        send("5");
        sclr = 1'b0;
        check("sclr_prio_ok",     32'(bus16.ok),     32'd0);
        check("sclr_prio_result", 32'(bus16.result), 32'd0);

        send_str16("9*9*9");
        check("t2_ok",     32'(bus16.ok),     32'd1);
        check("t2_result", 32'(bus16.result), 32'd729);
`ifdef EXPR_EVAL_OVF_EN
        check("t2_ovf16", 32'(bus16.ovf), 32'd0);
`endif
        send("+");
        check("t2_plus_ok",     32'(bus16.ok),     32'd0);
        check("t2_plus_result", 32'(bus16.result), 32'd729);
        send("1");
        check("t2_end_ok",     32'(bus16.ok),     32'd1);
        check("t2_end_result", 32'(bus16.result), 32'd730);

        pulse_sclr();
        send_str16("1+");
        check("t3_pre_err", 32'(bus16.err), 32'd0);
        send("+");
        check("t3_err",    32'(bus16.err),    32'd1);
        check("t3_ok",     32'(bus16.ok),     32'd0);
        check("t3_frozen", 32'(bus16.result), 32'd1);
        send("2");
        check("t3_sticky_err", 32'(bus16.err), 32'd1);
        check("t3_sticky_ok",  32'(bus16.ok),  32'd0);

        pulse_sclr();
        send_str16("12");
        check("t4_err", 32'(bus16.err), 32'd1);
        pulse_sclr();
        check("t4_clr_err", 32'(bus16.err), 32'd0);
        send("7");
        check("t4_err2",   32'(bus16.err),    32'd0);
        check("t4_ok",     32'(bus16.ok),     32'd1);
        check("t4_result", 32'(bus16.result), 32'd7);

        // Illegal leading bytes and a non-operator after a number
        pulse_sclr();
        send("a");
        check("empty_other_err", 32'(bus16.err), 32'd1);
        pulse_sclr();
        send("+");
        check("empty_plus_err", 32'(bus16.err), 32'd1);
        pulse_sclr();
        send_str16("5x");
        check("num_other_err", 32'(bus16.err), 32'd1);

        // Stalls with garbage on the bus must not disturb anything
        pulse_sclr();
        send("3");
        stall("*");
        stall("x");
        stall("9");
        check("t5_stall_ok",     32'(bus16.ok),     32'd1);
        check("t5_stall_result", 32'(bus16.result), 32'd3);
        send("+");
        stall("+");
        stall("8");
        check("t5_stall_op_ok", 32'(bus16.ok), 32'd0);
        send("4");
        check("t5_ok",     32'(bus16.ok),     32'd1);
        check("t5_result", 32'(bus16.result), 32'd7);

        send("*");
        #2;
        clr_n = 1'b0;
        #1;
        check("t5_async_ok",     32'(bus16.ok),     32'd0);
        check("t5_async_result", 32'(bus16.result), 32'd0);
        check("t5_async_err",    32'(bus16.err),    32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        send("5");
        check("t5_fresh_ok",     32'(bus16.ok),     32'd1);
        check("t5_fresh_result", 32'(bus16.result), 32'd5);

        // W=8: 9*9*9*9 = 6561 -> 161 mod 256
        pulse_sclr();
        for (int i = 0; i < 4; i++) begin
            send8("9");
            if (i < 3) send8("*");
        end
        check("w8_ok",     32'(bus8.ok),     32'd1);
        check("w8_result", 32'(bus8.result), 32'd161);
`ifdef EXPR_EVAL_OVF_EN
        check("w8_ovf", 32'(bus8.ovf), 32'd1);
        pulse_sclr();
        check("w8_ovf_clr", 32'(bus8.ovf), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
